// File: rtl/periph_pkg.sv
// Shared types and constants for the serial output peripheral.
package periph_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/periph_tx_sync_fifo.sv
// Synchronous word FIFO; callers must not push when full (unless popping) or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            if (pop)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign count   = count_r;
    assign full    = (count_r == CNT_W'(DEPTH));
    assign empty   = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/periph_tx.sv
// Memory-mapped UART-style word transmitter: FIFO-queued words sent as 4 bytes, LSB byte first.
// Optional even-parity bit per byte when PERIPH_TX_PARITY_EN is defined.
module periph_tx
    import periph_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WORD_W-1:0]        i_wr_data,
    input  logic                     i_clr_ovf,
    output logic                     o_tx,
    output logic                     o_busy,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [1:0]       BYTE_LAST = 2'(BYTES_PER_WORD - 1);

    tx_state_t          state_r, state_s;
    logic [TMR_W-1:0]   timer_r, timer_s;
    logic [2:0]         bit_r, bit_s;
    logic [1:0]         byte_r, byte_s;
    logic [WORD_W-1:0]  shift_r, shift_s;
    logic               tx_r, tx_s;
    logic               ovf_r;

    logic               pop_s;
    logic               push_s;
    logic               drop_s;
    logic [WORD_W-1:0]  head_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    // A pop frees a slot in the same cycle, so a write into a full FIFO is still accepted.
    assign push_s = i_wr_en & (~fifo_full_s | pop_s);
    assign drop_s = i_wr_en & fifo_full_s & ~pop_s;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (i_wr_data),
        .rd_data (head_s),
        .count   (fifo_count_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Frame sequencer state, counters, shift register and registered serial line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            timer_r <= {TMR_W{1'b0}};
            bit_r   <= 3'd0;
            byte_r  <= 2'd0;
            shift_r <= {WORD_W{1'b0}};
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            bit_r   <= bit_s;
            byte_r  <= byte_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
        end
    end

    // Next-state logic; o_tx is precomputed from the next state so the line is registered.
    always_comb begin
        state_s = state_r;
        timer_s = timer_r;
        bit_s   = bit_r;
        byte_s  = byte_r;
        shift_s = shift_r;
        pop_s   = 1'b0;
        tx_s    = 1'b1;

        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_s = head_s;
                    byte_s  = 2'd0;
                    bit_s   = 3'd0;
                    timer_s = {TMR_W{1'b0}};
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = {TMR_W{1'b0}};
                    bit_s   = 3'd0;
                    state_s = DATA;
                end else begin
                    timer_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            DATA: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = {TMR_W{1'b0}};
                    if (bit_r == BIT_LAST) begin
                        bit_s = 3'd0;
`ifdef PERIPH_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            PARITY: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = {TMR_W{1'b0}};
                    state_s = STOP;
                end else begin
                    timer_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            STOP: begin
                if (timer_r == TMR_LAST) begin
                    timer_s = {TMR_W{1'b0}};
                    if (byte_r != BYTE_LAST) begin
                        byte_s  = byte_r + 2'd1;
                        shift_s = {8'h00, shift_r[WORD_W-1:8]};
                        state_s = START;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    timer_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[bit_s];
            PARITY:  tx_s = even_parity(shift_s[DATA_BITS-1:0]);
            default: tx_s = 1'b1;
        endcase
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign o_tx       = tx_r;
    assign o_busy     = (fifo_count_s != {($clog2(DEPTH)+1){1'b0}}) | (state_r != IDLE);
    assign o_full     = fifo_full_s;
    assign o_count    = fifo_count_s;
    assign o_overflow = ovf_r;

endmodule

// File: tb/tb_periph_tx.sv
// Directed self-checking bench for periph_tx (DEPTH=4, CLKS_PER_BIT=4); honours PERIPH_TX_PARITY_EN.
module tb_periph_tx;

    localparam int CPB = 4;
`ifdef PERIPH_TX_PARITY_EN
    localparam int BPB = 11;
`else
    localparam int BPB = 10;
`endif
    localparam int FRAME = 4 * BPB * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wr_en;
    logic [31:0] i_wr_data;
    logic        i_clr_ovf;
    logic        o_tx;
    logic        o_busy;
    logic        o_full;
    logic [2:0]  o_count;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    periph_tx #(.DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_clr_ovf  (i_clr_ovf),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_count    (o_count),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge right after the pop edge; compares every cycle of the word's frame.
    task automatic expect_frame(input logic [31:0] word, input string tag);
        int          errs;
        logic [31:0] dec;
        logic [10:0] seq;
        logic [7:0]  d;
        errs = 0;
        dec  = 32'h0;
        for (int k = 0; k < 4; k++) begin
            d = word[8*k +: 8];
            seq = 11'h7FF;
            seq[0] = 1'b0;
            for (int i = 0; i < 8; i++) seq[1+i] = d[i];
            if (BPB == 11) seq[9] = ^d;
            seq[BPB-1] = 1'b1;
            for (int j = 0; j < BPB * CPB; j++) begin
                if (!(k == 0 && j == 0)) @(negedge clk);
                if (o_tx !== seq[j / CPB]) errs++;
                if ((j % CPB) == CPB / 2 && (j / CPB) >= 1 && (j / CPB) <= 8)
                    dec[8*k + (j / CPB) - 1] = o_tx;
            end
        end
        check({tag, "_bits"}, errs, 32'd0);
        check({tag, "_data"}, dec, word);
    endtask

    initial begin
        int lows;
        reset = 1'b1; i_wr_en = 1'b0; i_wr_data = 32'h0; i_clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", o_tx, 32'd1);
        check("rst_busy", o_busy, 32'd0);
        check("rst_full", o_full, 32'd0);
        check("rst_count", o_count, 32'd0);
        check("rst_ovf", o_overflow, 32'd0);
        reset = 1'b0;

        // Basic frame
        @(negedge clk);
        i_wr_en = 1'b1; i_wr_data = 32'h0000_00A5;
        @(negedge clk);
        i_wr_en = 1'b0;
        check("wr_count", o_count, 32'd1);
        check("wr_busy", o_busy, 32'd1);
        check("wr_tx_idle", o_tx, 32'd1);
        @(negedge clk);
        check("pop_count", o_count, 32'd0);
        expect_frame(32'h0000_00A5, "basic");
        check("busy_last", o_busy, 32'd1);
        @(negedge clk);
        check("busy_end", o_busy, 32'd0);
        check("tx_end", o_tx, 32'd1);

        // Fill and overflow: W1 pops at M+1, W2..W5 queue
        i_wr_en = 1'b1; i_wr_data = 32'hDEAD_BEEF;
        @(negedge clk); i_wr_data = 32'h4433_2211;
        @(negedge clk); i_wr_data = 32'hA5A5_0F0F;
        @(negedge clk); i_wr_data = 32'h8000_0001;
        @(negedge clk); i_wr_data = 32'hFFFF_FFFF;
        @(negedge clk);
        check("fill_count", o_count, 32'd4);
        check("fill_full", o_full, 32'd1);
        check("fill_ovf", o_overflow, 32'd0);
        i_wr_data = 32'h1234_5678;
        @(negedge clk);
        i_wr_en = 1'b0;
        check("drop_count", o_count, 32'd4);
        check("drop_ovf", o_overflow, 32'd1);
        i_clr_ovf = 1'b1;
        @(negedge clk);
        check("clr_ovf", o_overflow, 32'd0);
        i_wr_en = 1'b1; i_wr_data = 32'hCAFE_F00D;
        @(negedge clk);
        i_wr_en = 1'b0;
        check("set_wins_ovf", o_overflow, 32'd1);
        check("set_wins_count", o_count, 32'd4);
        @(negedge clk);
        i_clr_ovf = 1'b0;
        check("clr2_ovf", o_overflow, 32'd0);

        // Full with simultaneous pop: write on the IDLE cycle where W2 pops
        repeat (FRAME - 7) @(negedge clk);
        check("pre_pop_full", o_full, 32'd1);
        check("pre_pop_tx", o_tx, 32'd1);
        i_wr_en = 1'b1; i_wr_data = 32'h0000_0007;
        @(negedge clk);
        i_wr_en = 1'b0;
        check("popwr_count", o_count, 32'd4);
        check("popwr_ovf", o_overflow, 32'd0);
        check("popwr_full", o_full, 32'd1);
        expect_frame(32'h4433_2211, "byte_order");
        repeat (2) @(negedge clk);
        expect_frame(32'hA5A5_0F0F, "w3");
        repeat (2) @(negedge clk);
        expect_frame(32'h8000_0001, "w4");
        repeat (2) @(negedge clk);
        expect_frame(32'hFFFF_FFFF, "w5");
        repeat (2) @(negedge clk);
        check("w7_count", o_count, 32'd0);
        expect_frame(32'h0000_0007, "w7_parity");
        @(negedge clk);
        check("drain_busy", o_busy, 32'd0);

        // Reset mid-frame during byte 2 DATA with two words queued
        i_wr_en = 1'b1; i_wr_data = 32'h1111_1111;
        @(negedge clk); i_wr_data = 32'h2222_2222;
        @(negedge clk); i_wr_data = 32'h3333_3333;
        @(negedge clk);
        i_wr_en = 1'b0;
        repeat (2 * BPB * CPB + 2 * CPB - 1) @(negedge clk);
        check("mid_count", o_count, 32'd2);
        check("mid_busy", o_busy, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst_tx", o_tx, 32'd1);
        check("mrst_count", o_count, 32'd0);
        check("mrst_busy", o_busy, 32'd0);
        check("mrst_full", o_full, 32'd0);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx !== 1'b1) lows++;
        end
        check("mrst_quiet", lows, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
